// File: rtl/xbar_select_arbiter.sv
// Per-output crossbar selector that grants round-robin and holds the owner until its tail flit fires.
// Grant and release take one edge; selects are registered. Flow control is the caller's fire; no stall is generated here.
module xbar_select_arbiter #(
  parameter int N    = 5,
  parameter int IDXW = $clog2(N),
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    tail,
  input  logic            fire,
  output logic [N-1:0]    sel_onehot,
  output logic [IDXW-1:0] sel_idx,
  output logic            sel_valid,
  output logic [CNTW-1:0] flit_cnt
);

  localparam logic [0:0]      IDLE   = 1'b0;
  localparam logic [0:0]      LOCKED = 1'b1;
  localparam logic [IDXW:0]   NW     = (IDXW+1)'(N);
  localparam logic [IDXW-1:0] LAST   = IDXW'(N-1);

  logic [0:0]      state;
  logic [IDXW-1:0] owner;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] winner;
  logic            found;
  logic [IDXW:0]   cand;

  // Rotating priority search starting at ptr; the extra bit keeps ptr+k from wrapping before the mod-N fold.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IDXW+1)'(k);
      if (cand >= NW) cand = cand - NW;
      if (!found && req[cand[IDXW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDXW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      ptr        <= '0;
      sel_onehot <= '0;
      sel_idx    <= '0;
      sel_valid  <= 1'b0;
      flit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state      <= LOCKED;
            owner      <= winner;
            sel_idx    <= winner;
            sel_onehot <= {{(N-1){1'b0}}, 1'b1} << winner;
            sel_valid  <= 1'b1;
            flit_cnt   <= '0;
          end
        end
        LOCKED: begin
          if (fire) begin
            if (tail[owner]) begin
              // ptr only advances on release, bounding any requester's wait to N-1 packets.
              state      <= IDLE;
              ptr        <= (owner == LAST) ? '0 : owner + 1'b1;
              sel_onehot <= '0;
              sel_idx    <= '0;
              sel_valid  <= 1'b0;
              flit_cnt   <= '0;
            end else if (flit_cnt != {CNTW{1'b1}}) begin
              flit_cnt <= flit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xbar_select_arbiter.sv
// Directed bench for xbar_select_arbiter (N=5, CNTW=3) with hand-computed expectations.
module tb_xbar_select_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req;
  logic [4:0] tail;
  logic       fire;
  logic [4:0] sel_onehot;
  logic [2:0] sel_idx;
  logic       sel_valid;
  logic [2:0] flit_cnt;

  int total = 0;
  int bad   = 0;

  xbar_select_arbiter #(.N(5), .CNTW(3)) dut (
    .clk(clk), .rst(rst), .req(req), .tail(tail), .fire(fire),
    .sel_onehot(sel_onehot), .sel_idx(sel_idx), .sel_valid(sel_valid), .flit_cnt(flit_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_lock(input string tag, input int idx);
    logic [4:0] oh;
    oh = 5'd1 << idx;
    chk({tag, ".valid"}, 32'(sel_valid), 32'd1);
    chk({tag, ".idx"}, 32'(sel_idx), 32'(idx));
    chk({tag, ".onehot"}, 32'(sel_onehot), 32'(oh));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 32'(sel_valid), 32'd0);
    chk({tag, ".idx"}, 32'(sel_idx), 32'd0);
    chk({tag, ".onehot"}, 32'(sel_onehot), 32'd0);
    chk({tag, ".cnt"}, 32'(flit_cnt), 32'd0);
  endtask

  // Grant from IDLE with current req, then a 1-flit packet, leaving one bubble.
  task automatic one_flit_pkt(input string tag, input int exp_owner);
    fire = 1'b0; tail = 5'b0;
    tick();
    chk_lock(tag, exp_owner);
    fire = 1'b1; tail = 5'b11111;
    tick();
    chk({tag, ".bubble"}, 32'(sel_valid), 32'd0);
    chk({tag, ".cnt0"}, 32'(flit_cnt), 32'd0);
    fire = 1'b0; tail = 5'b0;
  endtask

  int rr_exp[5] = '{1, 2, 4, 1, 2};

  initial begin
    rst = 1'b1; req = 5'b11111; tail = 5'b0; fire = 1'b0;
    tick(); tick();
    chk_idle("reset");

    rst = 1'b0;
    tick();
    chk_lock("post_reset", 0);

    // Release owner 0 -> ptr=1.
    fire = 1'b1; tail = 5'b00001; req = 5'b10110;
    tick();
    chk("rel0.valid", 32'(sel_valid), 32'd0);

    // Round robin among {1,2,4} starting at ptr=1; ends with ptr=3.
    for (int i = 0; i < 5; i++) one_flit_pkt($sformatf("rr%0d", i), rr_exp[i]);

    // Lock hold on owner 2 (ptr=3, only req[2]).
    req = 5'b00100;
    tick();
    chk_lock("hold.grant", 2);
    fire = 1'b1; tail = 5'b0;
    tick(); tick(); tick();
    fire = 1'b0; req = 5'b00000;
    tick(); tick();
    req = 5'b00001;
    tick();
    chk_lock("hold.after_drop", 2);
    chk("hold.cnt", 32'(flit_cnt), 32'd3);
    tail = 5'b00100;
    tick();
    chk("hold.tail_nofire", 32'(sel_valid), 32'd1);
    fire = 1'b1;
    tick();
    chk_idle("hold.release");
    fire = 1'b0; tail = 5'b0;
    tick();
    chk_lock("hold.next", 0);

    // Release owner 0 -> ptr=1; fire while IDLE is ignored.
    req = 5'b0; fire = 1'b1; tail = 5'b00001;
    tick();
    tail = 5'b11111;
    tick();
    chk_idle("idle_fire");
    fire = 1'b0; tail = 5'b0; req = 5'b00010;
    tick();
    chk_lock("ign.grant", 1);
    fire = 1'b1; tail = 5'b01000;
    tick();
    chk("ign.other_tail.valid", 32'(sel_valid), 32'd1);
    chk("ign.other_tail.cnt", 32'(flit_cnt), 32'd1);
    fire = 1'b0; tail = 5'b00010;
    tick();
    chk("ign.tail_nofire.valid", 32'(sel_valid), 32'd1);
    chk("ign.tail_nofire.cnt", 32'(flit_cnt), 32'd1);
    fire = 1'b1;
    tick();
    chk("ign.release", 32'(sel_valid), 32'd0);

    // Wrap: owner 3 releases to ptr=4, then 4 beats 0, then 4 releases to ptr=0.
    fire = 1'b0; tail = 5'b0; req = 5'b01000;
    one_flit_pkt("wrap.o3", 3);
    req = 5'b10001;
    one_flit_pkt("wrap.o4", 4);
    tick();
    chk_lock("wrap.o0", 0);

    // Saturation on owner 0 with CNTW=3.
    fire = 1'b1; tail = 5'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("sat.cnt7", 32'(flit_cnt), 32'd7);
    tick(); tick();
    chk("sat.cnt9", 32'(flit_cnt), 32'd7);
    chk("sat.valid", 32'(sel_valid), 32'd1);
    tail = 5'b00001;
    tick();
    chk("sat.release", 32'(sel_valid), 32'd0);

    // Get ptr=4 with owner 4 mid-packet, then reset: ptr must return to 0 so 3 wins over 4.
    fire = 1'b0; tail = 5'b0; req = 5'b01000;
    one_flit_pkt("pre.o3", 3);
    req = 5'b10000;
    tick();
    chk_lock("pre.o4", 4);
    fire = 1'b1;
    tick(); tick();
    chk("pre.cnt", 32'(flit_cnt), 32'd2);
    fire = 1'b0; rst = 1'b1; req = 5'b11000;
    tick();
    chk_idle("midrst");
    rst = 1'b0;
    tick();
    chk_lock("midrst.grant", 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
